mux_stream_nway: RTL and testbench
==================================

Name: mux_stream_nway

Overview:
- Next-generation selector for the nand2tetris datapath: an N-channel, WIDTH-bit multiplexer with per-channel valid/ready handshakes and a registered output stage.
- Channel choice comes from an explicit select input (MODE_SEL) or from an internal round-robin arbiter (MODE_RR).
- Sits between multiple producers (ALU result, memory read data, I/O) and a single consumer such as a register load path or a UART TX queue.

Parameters:
- WIDTH, 16, data bits per channel (the Hack word width).
- N, 4, number of input channels; legal range 2..16.
- MODE, 0, 0 = MODE_SEL (explicit select), 1 = MODE_RR (round-robin).
- SEL_W, $clog2(N), select and channel-id width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; combinational.
- sel  in  SEL_W  channel select; used only in MODE_SEL.
- out_data  out  WIDTH  registered output word.
- out_chan  out  SEL_W  registered index of the source channel of out_data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset: rst_n low asynchronously clears state. out_valid=0, out_data=0, out_chan=0, rr_ptr=N-1 (channel 0 has first priority).
- Output stage: one-entry register. load_en = !out_valid | out_ready.
- Transfer rules:
  - An input transfer happens when in_valid[g] & in_ready[g].
  - An output transfer happens when out_valid & out_ready.
  - Both may occur in the same cycle, giving full throughput of 1 word/cycle.
- Latency: an accepted input appears on out_data/out_valid exactly 1 cycle later.
- Grant, MODE_SEL:
  - g = sel, evaluated combinationally in the same cycle.
  - in_ready[i] = load_en & (i==sel).
  - sel >= N: no grant, all in_ready=0, output stage drains normally.
- Grant, MODE_RR:
  - g = first i with in_valid[i]=1, searching circularly from rr_ptr+1.
  - in_ready[g] = load_en; all other in_ready bits = 0.
  - No channel valid: in_ready = 0.
  - rr_ptr <= g only on a completed input transfer. Without a transfer (stall or no requests) the pointer holds.
  - Wrap-around: the search after channel N-1 continues at channel 0.
- At most one in_ready bit is high in any cycle, in either mode.
- On an input transfer: out_data <= in_data[g], out_chan <= g, out_valid <= 1.
- On an output transfer with no input transfer: out_valid <= 0. out_data and out_chan hold their last value.
- Stall (out_valid=1 & out_ready=0):
  - out_data, out_chan and out_valid are held stable.
  - all in_ready = 0.
- in_ready never depends on in_valid of the granted channel in MODE_SEL. In MODE_RR it depends on in_valid combinationally; there is no loop because in_valid must not depend on in_ready (standard valid/ready rule).
- Reset mid-operation: a pending output word is discarded, out_valid drops immediately, and rr_ptr returns to N-1. After rst_n deasserts, the first grant goes to the lowest valid channel.
- Illegal N (<2 or >16): elaboration error.

Decomposition:
- Package mux_pkg holds:
  - MODE_SEL=0 and MODE_RR=1 localparams.
  - a function clog2_min1 used for SEL_W.
- Sub-module rr_arbiter (N): inputs req[N], ptr, advance; outputs grant_onehot, grant_idx, holding the rotating priority and pointer register.
- MODE_SEL bypasses rr_arbiter through a generate branch.
- The word select is an AND-OR tree over the one-hot grant, consistent with the gate-level mux style of the codebase.

Test Plan:
- MODE_SEL, sel=2, in_valid=4'b0100, in_data ch2=16'hBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=16'hBEEF, out_chan=2.
- MODE_SEL, stall: out_valid=1, out_ready=0 for 3 cycles with ch1 valid -> in_ready=0 and out_data unchanged throughout. out_ready=1 -> ch1 word is accepted in the same cycle and appears next cycle.
- MODE_SEL, N=3, sel=3 with all valid -> in_ready=3'b000 and out_valid stays 0.
- MODE_RR, N=4, all four valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 at 1 word/cycle.
- MODE_RR, only ch3 and ch1 valid, rr_ptr=3 -> grant ch1, then ch3, then ch1 (wrap-around). Dropping out_ready for 2 cycles holds rr_ptr, and the next grant is unchanged.
- Reset mid-stream: rst_n low while out_valid=1 (asynchronous, between clock edges) -> out_valid=0 immediately. After release with all channels valid, the first out_chan=0.

Source files
------------

// File: rtl/mux_stream_nway_pkg.sv
// rtl/mux_stream_nway_pkg.sv - shared mode constants and width helper for the stream mux
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Select/channel-id width; never zero so a 1-bit field exists even for tiny N.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_stream_nway_if.sv
// rtl/mux_stream_nway_if.sv - N-channel input and single output handshake bundle
interface mux_stream_nway_if
    import mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4
);
    localparam int SEL_W = clog2_min1(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_chan;
    logic               out_valid;
    logic               out_ready;

    // Design side: consumes channel inputs, drives the registered output.
    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    // Environment side: producers plus the downstream consumer.
    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_stream_nway_rr_arbiter.sv
// rtl/mux_stream_nway_rr_arbiter.sv - rotating-priority arbiter with its own pointer register
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int  N     = 4,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_onehot_o,
    output logic [SEL_W-1:0] grant_idx_o
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W:0]   cand;
    logic             found;

    // Scan from ptr+1 circularly; the extra bit in cand absorbs ptr+k before wrapping.
    always_comb begin
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        found          = 1'b0;
        cand           = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, ptr_q} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(N)) begin
                cand = cand - (SEL_W+1)'(N);
            end
            if (!found && req_i[cand[SEL_W-1:0]]) begin
                found                              = 1'b1;
                grant_onehot_o[cand[SEL_W-1:0]]    = 1'b1;
                grant_idx_o                        = cand[SEL_W-1:0];
            end
        end
    end

    // Pointer moves to the winner only when its word was actually taken.
    always_comb begin
        ptr_d = advance_i ? grant_idx_o : ptr_q;
    end

    // Pointer register; N-1 after reset so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SEL_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mux_stream_nway.sv
// rtl/mux_stream_nway.sv - N-way valid/ready stream mux with registered one-entry output
module mux_stream_nway
    import mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int MODE  = MODE_SEL
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_stream_nway_if.slave  bus
);

    localparam int SEL_W = clog2_min1(N);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("mux_stream_nway: N must be in 2..16");
    end

    logic [N-1:0]     grant_onehot;
    logic [SEL_W-1:0] grant_idx;
    logic [N-1:0]     in_ready_w;
    logic             load_en;
    logic             in_xfer;
    logic [WIDTH-1:0] word_sel;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;

    if (MODE == MODE_RR) begin : g_rr
        rr_arbiter #(.N(N)) u_arb (
            .clk            (clk),
            .rst_n          (rst_n),
            .req_i          (bus.in_valid),
            .advance_i      (in_xfer),
            .grant_onehot_o (grant_onehot),
            .grant_idx_o    (grant_idx)
        );
        logic unused_sel;
        assign unused_sel = ^bus.sel;
    end else begin : g_sel
        // Out-of-range select decodes to no grant at all.
        for (genvar i = 0; i < N; i++) begin : g_dec
            assign grant_onehot[i] = (bus.sel == SEL_W'(i));
        end
        assign grant_idx = bus.sel;
    end

    assign load_en    = !out_valid_q || bus.out_ready;
    assign in_ready_w = grant_onehot & {N{load_en}};
    assign in_xfer    = |(in_ready_w & bus.in_valid);

    // AND-OR word select over the one-hot grant.
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < N; i++) begin
            word_sel = word_sel | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_onehot[i]}});
        end
    end

    // Load on input transfer, otherwise drop valid once the consumer takes the word.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (in_xfer) begin
            out_data_d  = word_sel;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage register; reset discards any pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_stream_nway.sv
// tb/tb_mux_stream_nway.sv - directed self-checking bench for mux_stream_nway
module tb_mux_stream_nway;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    mux_stream_nway_if #(.WIDTH(16), .N(4)) bus_sel ();
    mux_stream_nway_if #(.WIDTH(16), .N(3)) bus_sel3 ();
    mux_stream_nway_if #(.WIDTH(16), .N(4)) bus_rr ();

    mux_stream_nway #(.WIDTH(16), .N(4), .MODE(0)) u_sel  (.clk(clk), .rst_n(rst_n), .bus(bus_sel));
    mux_stream_nway #(.WIDTH(16), .N(3), .MODE(0)) u_sel3 (.clk(clk), .rst_n(rst_n), .bus(bus_sel3));
    mux_stream_nway #(.WIDTH(16), .N(4), .MODE(1)) u_rr   (.clk(clk), .rst_n(rst_n), .bus(bus_rr));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus_sel.in_data = '0;  bus_sel.in_valid = '0;  bus_sel.sel = '0;  bus_sel.out_ready = 1'b0;
        bus_sel3.in_data = '0; bus_sel3.in_valid = '0; bus_sel3.sel = '0; bus_sel3.out_ready = 1'b0;
        bus_rr.in_data = '0;   bus_rr.in_valid = '0;   bus_rr.sel = '0;   bus_rr.out_ready = 1'b0;
        #12;
        total++; if (bus_sel.out_valid !== 1'b0) $display("FAIL reset_sel_valid got=%b exp=0", bus_sel.out_valid); else passed++;
        total++; if (bus_sel.out_data !== 16'h0) $display("FAIL reset_sel_data got=%h exp=0000", bus_sel.out_data); else passed++;
        total++; if (bus_sel.out_chan !== 2'd0) $display("FAIL reset_sel_chan got=%0d exp=0", bus_sel.out_chan); else passed++;
        total++; if (bus_rr.out_valid !== 1'b0) $display("FAIL reset_rr_valid got=%b exp=0", bus_rr.out_valid); else passed++;
        total++; if (bus_rr.in_ready !== 4'b0000) $display("FAIL reset_rr_ready got=%b exp=0000", bus_rr.in_ready); else passed++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sel_basic();
        bus_sel.in_data   = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
        bus_sel.sel       = 2'd2;
        bus_sel.in_valid  = 4'b0100;
        bus_sel.out_ready = 1'b1;
        #1;
        total++; if (bus_sel.in_ready !== 4'b0100) $display("FAIL sel_in_ready got=%b exp=0100", bus_sel.in_ready); else passed++;
        step();
        bus_sel.in_valid = 4'b0000;
        total++; if (bus_sel.out_valid !== 1'b1) $display("FAIL sel_out_valid got=%b exp=1", bus_sel.out_valid); else passed++;
        total++; if (bus_sel.out_data !== 16'hBEEF) $display("FAIL sel_out_data got=%h exp=beef", bus_sel.out_data); else passed++;
        total++; if (bus_sel.out_chan !== 2'd2) $display("FAIL sel_out_chan got=%0d exp=2", bus_sel.out_chan); else passed++;
        step();
        total++; if (bus_sel.out_valid !== 1'b0) $display("FAIL sel_drain_valid got=%b exp=0", bus_sel.out_valid); else passed++;
        total++; if (bus_sel.out_data !== 16'hBEEF) $display("FAIL sel_drain_hold got=%h exp=beef", bus_sel.out_data); else passed++;
    endtask

    task automatic test_sel_stall();
        bus_sel.in_data   = {16'h4444, 16'hA001, 16'hC0DE, 16'h1111};
        bus_sel.sel       = 2'd2;
        bus_sel.in_valid  = 4'b0100;
        bus_sel.out_ready = 1'b1;
        step();
        bus_sel.out_ready = 1'b0;
        bus_sel.sel       = 2'd1;
        bus_sel.in_valid  = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus_sel.in_ready !== 4'b0000) $display("FAIL stall_ready[%0d] got=%b exp=0000", i, bus_sel.in_ready); else passed++;
            total++; if (bus_sel.out_data !== 16'hA001) $display("FAIL stall_data[%0d] got=%h exp=a001", i, bus_sel.out_data); else passed++;
            total++; if (bus_sel.out_valid !== 1'b1) $display("FAIL stall_valid[%0d] got=%b exp=1", i, bus_sel.out_valid); else passed++;
            step();
        end
        bus_sel.out_ready = 1'b1;
        #1;
        total++; if (bus_sel.in_ready !== 4'b0010) $display("FAIL unstall_ready got=%b exp=0010", bus_sel.in_ready); else passed++;
        step();
        bus_sel.in_valid = 4'b0000;
        total++; if (bus_sel.out_data !== 16'hC0DE) $display("FAIL unstall_data got=%h exp=c0de", bus_sel.out_data); else passed++;
        total++; if (bus_sel.out_chan !== 2'd1) $display("FAIL unstall_chan got=%0d exp=1", bus_sel.out_chan); else passed++;
        step();
    endtask

    task automatic test_sel_out_of_range();
        bus_sel3.in_data   = {16'h3333, 16'h2222, 16'h1111};
        bus_sel3.sel       = 2'd3;
        bus_sel3.in_valid  = 3'b111;
        bus_sel3.out_ready = 1'b1;
        #1;
        total++; if (bus_sel3.in_ready !== 3'b000) $display("FAIL oor_ready got=%b exp=000", bus_sel3.in_ready); else passed++;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (bus_sel3.out_valid !== 1'b0) $display("FAIL oor_valid[%0d] got=%b exp=0", i, bus_sel3.out_valid); else passed++;
        end
        bus_sel3.sel = 2'd1;
        #1;
        total++; if (bus_sel3.in_ready !== 3'b010) $display("FAIL n3_ready got=%b exp=010", bus_sel3.in_ready); else passed++;
        step();
        bus_sel3.in_valid = 3'b000;
        total++; if (bus_sel3.out_data !== 16'h2222) $display("FAIL n3_data got=%h exp=2222", bus_sel3.out_data); else passed++;
        total++; if (bus_sel3.out_chan !== 2'd1) $display("FAIL n3_chan got=%0d exp=1", bus_sel3.out_chan); else passed++;
        step();
    endtask

    task automatic test_rr_sequence();
        int exp_chan [6] = '{0, 1, 2, 3, 0, 1};
        bus_rr.in_data   = {16'hA0A3, 16'hA0A2, 16'hA0A1, 16'hA0A0};
        bus_rr.in_valid  = 4'b1111;
        bus_rr.out_ready = 1'b1;
        #1;
        total++; if (bus_rr.in_ready !== 4'b0001) $display("FAIL rr_first_ready got=%b exp=0001", bus_rr.in_ready); else passed++;
        for (int k = 0; k < 6; k++) begin
            step();
            total++; if (bus_rr.out_chan !== 2'(exp_chan[k])) $display("FAIL rr_seq_chan[%0d] got=%0d exp=%0d", k, bus_rr.out_chan, exp_chan[k]); else passed++;
            total++; if (bus_rr.out_valid !== 1'b1) $display("FAIL rr_seq_valid[%0d] got=%b exp=1", k, bus_rr.out_valid); else passed++;
            total++; if (bus_rr.out_data !== 16'hA0A0 + 16'(exp_chan[k])) $display("FAIL rr_seq_data[%0d] got=%h exp=%h", k, bus_rr.out_data, 16'hA0A0 + 16'(exp_chan[k])); else passed++;
        end
        bus_rr.in_valid = 4'b0000;
        step();
        total++; if (bus_rr.out_valid !== 1'b0) $display("FAIL rr_drain_valid got=%b exp=0", bus_rr.out_valid); else passed++;
    endtask

    task automatic test_rr_wrap();
        // One ch3-only word parks the pointer on 3.
        bus_rr.in_valid = 4'b1000;
        step();
        bus_rr.in_valid = 4'b0000;
        total++; if (bus_rr.out_chan !== 2'd3) $display("FAIL wrap_park_chan got=%0d exp=3", bus_rr.out_chan); else passed++;
        step();
        bus_rr.in_valid = 4'b1010;
        #1;
        total++; if (bus_rr.in_ready !== 4'b0010) $display("FAIL wrap_first_ready got=%b exp=0010", bus_rr.in_ready); else passed++;
        step();
        total++; if (bus_rr.out_chan !== 2'd1) $display("FAIL wrap_chan0 got=%0d exp=1", bus_rr.out_chan); else passed++;
        step();
        total++; if (bus_rr.out_chan !== 2'd3) $display("FAIL wrap_chan1 got=%0d exp=3", bus_rr.out_chan); else passed++;
        step();
        total++; if (bus_rr.out_chan !== 2'd1) $display("FAIL wrap_chan2 got=%0d exp=1", bus_rr.out_chan); else passed++;
        bus_rr.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (bus_rr.in_ready !== 4'b0000) $display("FAIL rr_stall_ready[%0d] got=%b exp=0000", i, bus_rr.in_ready); else passed++;
            step();
            total++; if (bus_rr.out_chan !== 2'd1) $display("FAIL rr_stall_chan[%0d] got=%0d exp=1", i, bus_rr.out_chan); else passed++;
        end
        bus_rr.out_ready = 1'b1;
        #1;
        total++; if (bus_rr.in_ready !== 4'b1000) $display("FAIL rr_resume_ready got=%b exp=1000", bus_rr.in_ready); else passed++;
        step();
        bus_rr.in_valid = 4'b0000;
        total++; if (bus_rr.out_chan !== 2'd3) $display("FAIL rr_resume_chan got=%0d exp=3", bus_rr.out_chan); else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        bus_rr.in_valid  = 4'b1111;
        bus_rr.out_ready = 1'b1;
        step();
        step();
        total++; if (bus_rr.out_valid !== 1'b1) $display("FAIL pre_reset_valid got=%b exp=1", bus_rr.out_valid); else passed++;
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (bus_rr.out_valid !== 1'b0) $display("FAIL async_reset_valid got=%b exp=0", bus_rr.out_valid); else passed++;
        total++; if (bus_rr.out_data !== 16'h0) $display("FAIL async_reset_data got=%h exp=0000", bus_rr.out_data); else passed++;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        total++; if (bus_rr.in_ready !== 4'b0001) $display("FAIL post_reset_ready got=%b exp=0001", bus_rr.in_ready); else passed++;
        step();
        total++; if (bus_rr.out_chan !== 2'd0) $display("FAIL post_reset_chan got=%0d exp=0", bus_rr.out_chan); else passed++;
        total++; if (bus_rr.out_data !== 16'hA0A0) $display("FAIL post_reset_data got=%h exp=a0a0", bus_rr.out_data); else passed++;
        bus_rr.in_valid = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_sel_basic();
        test_sel_stall();
        test_sel_out_of_range();
        test_rr_sequence();
        test_rr_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
